extract: RTL and testbench
==========================

EXTRACT -- requirements
Module: extract

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DWIDTH, default 16: data word width in bits.
REQ-003 Parameter LWIDTH, default 10: element index, offset and count width in bits.
REQ-004 Port clk  in  1  rising-edge clock for all state.
REQ-005 Port rst  in  1  synchronous active-high reset.
REQ-006 Port req  in  1  single-cycle start pulse; accepted only in IDLE.
REQ-007 Port offset  in  LWIDTH  index of the first element to extract; sampled on an accepted req.
REQ-008 Port count  in  LWIDTH  number of elements to extract; sampled on an accepted req.
REQ-009 Port in_valid  in  1  the input element is present this cycle.
REQ-010 Port in_data  in  DWIDTH  input element.
REQ-011 Port in_last  in  1  marks the final element of the input frame; qualified by in_valid.
REQ-012 Port out_valid  out  1  out_data is an extracted element.
REQ-013 Port out_data  out  DWIDTH  extracted element.
REQ-014 Port out_last  out  1  marks the final extracted element.
REQ-015 Port busy  out  1  high in every state other than IDLE.
REQ-016 Port done  out  1  single-cycle pulse when an extraction completes.
REQ-017 Port short_err  out  1  valid with done; the frame ended before count elements were extracted.

Function
REQ-018 States SHALL be IDLE, SKIP, PASS and DONE.
REQ-019 IDLE->SKIP on req when count!=0; IDLE->DONE on req when count==0, with short_err=0.
REQ-020 In SKIP and PASS, an element index counter SHALL start at 0 and increment on each in_valid.
REQ-021 SKIP->PASS when the element with index==offset arrives; that element is forwarded.
REQ-022 In PASS, each in_valid element SHALL be forwarded until count elements have been forwarded; then PASS->DONE.
REQ-023 Forwarded elements SHALL appear on out_data/out_valid exactly 1 cycle after the in_valid cycle, registered.
REQ-024 out_last SHALL accompany the count-th forwarded element only.
REQ-025 in_last in SKIP or PASS before count elements are forwarded SHALL go to DONE with short_err=1; out_last SHALL go on the last forwarded element, if there is one.
REQ-026 An in_last that coincides with the count-th element SHALL complete normally, with short_err=0.
REQ-027 DONE SHALL assert done for one cycle and return to IDLE; input elements are ignored in IDLE and DONE.
REQ-028 req while busy SHALL be ignored.
REQ-029 The end index offset+count SHALL be computed at LWIDTH+1 bits so that it cannot wrap.

Reset
REQ-030 On rst, the state SHALL be IDLE and the counters SHALL be 0.
REQ-031 On rst, out_valid, out_last, done and short_err SHALL be 0, and out_data SHALL be 0.
REQ-032 rst mid-extraction SHALL abort without asserting done.

Configuration
REQ-033 With EXTRACT_STRIDE_EN defined, an input port stride (LWIDTH bits, sampled with req) SHALL be present; PASS forwards every stride-th element starting at offset, and stride 0 is treated as 1.
REQ-034 Without EXTRACT_STRIDE_EN, the stride port SHALL be absent and the stride SHALL be fixed at 1.

Structure
REQ-035 The DWIDTH/LWIDTH defaults and the state enum SHALL live in the shared package extract_pkg.
REQ-036 The index/forward counting SHALL be one sub-module, extract_ctr; everything else is flat.

Verification
REQ-037 offset=2, count=3, a frame of 8 elements with data 10..17 -> out 12,13,14; out_last with 14; done with short_err=0.
REQ-038 count=0 -> done 2 cycles after req; no out_valid at any point.
REQ-039 offset=5, count=4, a 7-element frame -> out elements 5,6; out_last with element 6; short_err=1.
REQ-040 Gapped in_valid (every other cycle), offset=0, count=2 -> each output follows its input by exactly 1 cycle.
REQ-041 rst during PASS -> all outputs 0 next cycle; no done; a new req is accepted afterwards.
REQ-042 With EXTRACT_STRIDE_EN: offset=1, count=3, stride=2 over data 0..9 -> out 1,3,5.

Source files
------------

// File: rtl/extract_pkg.sv
// extract_pkg: shared definitions for the extract block.
//   DWIDTH_DEF / LWIDTH_DEF : default data and index widths
//   state_t                 : extraction FSM state encoding
package extract_pkg;

  localparam int unsigned DWIDTH_DEF = 16;
  localparam int unsigned LWIDTH_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    PASS = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/extract_ctr.sv
// extract_ctr: element index / forward counting for extract.
// Build option: EXTRACT_STRIDE_EN adds the stride input.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          accepted request; loads offset/count (and stride)
//   active         FSM is in SKIP or PASS
//   in_valid       an input element is present this cycle
//   offset, count  extraction window, sampled on start
//   stride         (EXTRACT_STRIDE_EN only) element spacing, 0 means 1
//   hit            current element is to be forwarded
//   last_hit       current element is the count-th forwarded element
module extract_ctr
  import extract_pkg::*;
#(
  parameter int unsigned LWIDTH = LWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              active,
  input  logic              in_valid,
  input  logic [LWIDTH-1:0] offset,
  input  logic [LWIDTH-1:0] count,
`ifdef EXTRACT_STRIDE_EN
  input  logic [LWIDTH-1:0] stride,
`endif
  output logic              hit,
  output logic              last_hit
);

  localparam logic [LWIDTH:0] IDX_ONE = {{LWIDTH{1'b0}}, 1'b1};

  // One extra bit so offset+count and the running index never wrap.
  logic [LWIDTH:0] idx;

`ifdef EXTRACT_STRIDE_EN
  // Next index to forward and number forwarded so far.
  logic [LWIDTH:0]   nxt;
  logic [LWIDTH-1:0] stride_r;
  logic [LWIDTH-1:0] count_r;
  logic [LWIDTH-1:0] fwd;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      nxt      <= '0;
      stride_r <= '0;
      count_r  <= '0;
      fwd      <= '0;
    end else if (start) begin
      idx      <= '0;
      nxt      <= {1'b0, offset};
      stride_r <= (stride == '0) ? {{(LWIDTH-1){1'b0}}, 1'b1} : stride;
      count_r  <= count;
      fwd      <= '0;
    end else if (active && in_valid) begin
      idx <= idx + IDX_ONE;
      if (hit) begin
        nxt <= nxt + {1'b0, stride_r};
        fwd <= fwd + {{(LWIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    hit      = active && in_valid && (idx == nxt);
    last_hit = hit && (fwd == (count_r - {{(LWIDTH-1){1'b0}}, 1'b1}));
  end
`else
  logic [LWIDTH:0] offset_r;
  logic [LWIDTH:0] end_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      offset_r <= '0;
      end_r    <= '0;
    end else if (start) begin
      idx      <= '0;
      offset_r <= {1'b0, offset};
      end_r    <= {1'b0, offset} + {1'b0, count};
    end else if (active && in_valid) begin
      idx <= idx + IDX_ONE;
    end
  end

  // Unit stride: the forwarded window is simply [offset, offset+count).
  always_comb begin
    hit      = active && in_valid && (idx >= offset_r) && (idx < end_r);
    last_hit = hit && ((idx + IDX_ONE) == end_r);
  end
`endif

endmodule

// File: rtl/extract.sv
// extract: forwards count elements of an input frame starting at offset.
// Build option: EXTRACT_STRIDE_EN adds a stride input (every stride-th
// element from offset is forwarded; stride 0 behaves as 1).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req, offset, count, stride  start pulse and its parameters (IDLE only)
//   in_valid, in_data, in_last  input element stream
//   out_valid, out_data, out_last  registered extracted elements (1 cycle)
//   busy                        FSM not in IDLE
//   done, short_err             completion pulse; short_err = frame ran out
module extract
  import extract_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned LWIDTH = LWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [LWIDTH-1:0] offset,
  input  logic [LWIDTH-1:0] count,
`ifdef EXTRACT_STRIDE_EN
  input  logic [LWIDTH-1:0] stride,
`endif
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              short_err
);

  state_t state, state_n;
  logic   short_r, short_n;
  logic   start, active, hit, last_hit;

  assign start  = (state == IDLE) && req;
  assign active = (state == SKIP) || (state == PASS);
  assign busy   = (state != IDLE);

  extract_ctr #(
    .LWIDTH(LWIDTH)
  ) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .active   (active),
    .in_valid (in_valid),
    .offset   (offset),
    .count    (count),
`ifdef EXTRACT_STRIDE_EN
    .stride   (stride),
`endif
    .hit      (hit),
    .last_hit (last_hit)
  );

  always_comb begin
    state_n = state;
    short_n = short_r;
    case (state)
      IDLE: begin
        if (req) begin
          short_n = 1'b0;
          state_n = (count == '0) ? DONE : SKIP;
        end
      end
      SKIP, PASS: begin
        // Reaching count wins over a coincident in_last.
        if (last_hit) begin
          state_n = DONE;
          short_n = 1'b0;
        end else if (in_valid && in_last) begin
          state_n = DONE;
          short_n = 1'b1;
        end else if (hit) begin
          state_n = PASS;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      short_r   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      short_err <= 1'b0;
    end else begin
      state     <= state_n;
      short_r   <= short_n;
      out_valid <= hit;
      if (hit) out_data <= in_data;
      out_last  <= hit && (last_hit || in_last);
      done      <= (state == DONE);
      short_err <= (state == DONE) && short_r;
    end
  end

endmodule

// File: tb/tb_extract.sv
// tb_extract: scoreboard bench for extract. Expected output elements are
// queued as input is driven and popped by the output monitor.
module tb_extract;
  import extract_pkg::*;

  localparam int DW = 16;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [LW-1:0] offset;
  logic [LW-1:0] count;
`ifdef EXTRACT_STRIDE_EN
  logic [LW-1:0] stride;
`endif
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          short_err;

  extract #(
    .DWIDTH(DW),
    .LWIDTH(LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .offset    (offset),
    .count     (count),
`ifdef EXTRACT_STRIDE_EN
    .stride    (stride),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .short_err (short_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic done_short = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_last", 32'(out_last), 32'(e.last));
        check("out_latency", 32'(cyc - e.cyc), 32'd1);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc   = cyc;
      done_short = short_err;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int off, input int cnt, input int len, input int str,
                     input int base, input bit gap, input bit busy_req);
    int   k = 0;
    int   s;
    int   d0;
    int   req_cyc;
    exp_t e;
    s = (str == 0) ? 1 : str;
    d0 = done_cnt;
    req = 1'b1;
    offset = LW'(off);
    count = LW'(cnt);
`ifdef EXTRACT_STRIDE_EN
    stride = LW'(str);
`endif
    req_cyc = cyc;
    tick;
    req = 1'b0;
    check("busy_after_req", 32'(busy), 32'd1);
    for (int i = 0; i < len; i++) begin
      if (gap && i > 0) begin
        in_valid = 1'b0;
        tick;
      end
      in_valid = 1'b1;
      in_data  = DW'(base + i);
      in_last  = (i == len - 1);
      if (busy_req && i == 1) begin
        req = 1'b1;
        offset = '0;
        count = LW'(1);
      end
      if (k < cnt && i >= off && ((i - off) % s) == 0) begin
        e.data = DW'(base + i);
        e.last = (k + 1 == cnt) || (i == len - 1);
        e.cyc  = cyc;
        q.push_back(e);
        k++;
      end
      tick;
      req = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int t = 0; t < 10 && done_cnt == d0; t++) tick;
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("short_err", 32'(done_short), 32'(k < cnt));
    if (cnt == 0) check("done_latency", 32'(done_cyc - req_cyc), 32'd2);
    tick;
    tick;
    check("queue_drained", 32'(q.size()), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int   d0;
    exp_t e;
    rst = 1'b1;
    req = 1'b0;
    offset = '0;
    count = '0;
`ifdef EXTRACT_STRIDE_EN
    stride = '0;
`endif
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    repeat (3) tick;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_short_err", 32'(short_err), 32'd0);
    rst = 1'b0;
    tick;

    run(2, 3, 8, 1, 10, 1'b0, 1'b1);   // 12,13,14; req while busy ignored
    run(0, 0, 0, 1, 0, 1'b0, 1'b0);    // count 0: done only
    run(5, 4, 7, 1, 0, 1'b0, 1'b0);    // short frame: 5,6
    run(0, 2, 4, 1, 40, 1'b1, 1'b0);   // gapped input
    run(1, 3, 4, 1, 60, 1'b0, 1'b0);   // in_last on count-th element
    run(9, 2, 4, 1, 80, 1'b0, 1'b0);   // offset past frame end
    run(0, 1, 1, 1, 90, 1'b0, 1'b0);   // single element frame

    // Reset while in PASS.
    d0 = done_cnt;
    req = 1'b1;
    offset = '0;
    count = LW'(5);
    tick;
    req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(100 + i);
      e.data = DW'(100 + i);
      e.last = 1'b0;
      e.cyc  = cyc;
      q.push_back(e);
      tick;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_last", 32'(out_last), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_short_err", 32'(short_err), 32'd0);
    repeat (5) tick;
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_queue", 32'(q.size()), 32'd0);
    run(3, 2, 6, 1, 200, 1'b0, 1'b0);  // accepted after reset

`ifdef EXTRACT_STRIDE_EN
    run(1, 3, 10, 2, 0, 1'b0, 1'b0);   // 1,3,5
    run(0, 2, 4, 0, 20, 1'b0, 1'b0);   // stride 0 acts as 1
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
